// File: rtl/instr_fetch.sv
// instr_fetch: CR16 fetch responder -- issues instruction-memory reads, tracks in-flight tags and
// buffers returned words in a first-word-fall-through FIFO. Optional stats: INSTR_FETCH_STATS_EN.
module instr_fetch #(
   parameter int unsigned P_ADDRESS_WIDTH = 16,
   parameter int unsigned P_DATA_WIDTH    = 16,
   parameter int unsigned P_MEM_LATENCY   = 1,
   parameter int unsigned P_FIFO_DEPTH    = 4
) (
   input  logic                       I_CLK,
   input  logic                       I_RESET,
   input  logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS,
   input  logic                       I_ADDRESS_VALID,
   output logic                       O_ADDRESS_READY,
   output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
   output logic                       O_MEM_READ,
   input  logic [P_DATA_WIDTH-1:0]    I_MEM_DATA,
   input  logic                       I_FLUSH,
   output logic [P_DATA_WIDTH-1:0]    O_INSTR,
   output logic [P_ADDRESS_WIDTH-1:0] O_INSTR_ADDRESS,
   output logic                       O_INSTR_VALID,
`ifdef INSTR_FETCH_STATS_EN
   output logic [15:0]                O_FETCH_COUNT,
   output logic [15:0]                O_DISCARD_COUNT,
`endif
   input  logic                       I_INSTR_READY
);

   localparam int unsigned LP_PTR_W = $clog2(P_FIFO_DEPTH);
   localparam int unsigned LP_CNT_W = $clog2(P_FIFO_DEPTH) + 1;
   localparam int unsigned LP_SUM_W = LP_CNT_W + 1;

   logic                       accept;
   logic                       credit_ok;
   logic [LP_SUM_W-1:0]        pending_sum;

   logic [P_MEM_LATENCY-1:0]   stage_valid_q;
   logic [P_ADDRESS_WIDTH-1:0] stage_addr_q [P_MEM_LATENCY];
   logic                       ret_valid;
   logic [P_ADDRESS_WIDTH-1:0] ret_addr;
   logic [LP_CNT_W-1:0]        inflight_count_q;
   logic [LP_CNT_W-1:0]        inflight_count_d;

   logic [P_DATA_WIDTH-1:0]    fifo_data_q [P_FIFO_DEPTH];
   logic [P_ADDRESS_WIDTH-1:0] fifo_addr_q [P_FIFO_DEPTH];
   logic [LP_PTR_W-1:0]        wr_ptr_q;
   logic [LP_PTR_W-1:0]        rd_ptr_q;
   logic [LP_CNT_W-1:0]        fifo_count_q;
   logic [LP_CNT_W-1:0]        fifo_count_d;
   logic                       push;
   logic                       pop;

   // Credit counts buffered plus outstanding reads, so a returning word always has a slot.
   always_comb begin
      pending_sum     = {1'b0, fifo_count_q} + {1'b0, inflight_count_q};
      credit_ok       = pending_sum < LP_SUM_W'(P_FIFO_DEPTH);
      O_ADDRESS_READY = !I_RESET && !I_FLUSH && credit_ok;
      accept          = I_ADDRESS_VALID && O_ADDRESS_READY;
      O_MEM_ADDRESS   = I_ADDRESS;
      O_MEM_READ      = accept;
   end

   always_comb begin
      ret_valid = stage_valid_q[P_MEM_LATENCY-1];
      ret_addr  = stage_addr_q[P_MEM_LATENCY-1];
      push      = ret_valid && !I_FLUSH;
      pop       = O_INSTR_VALID && I_INSTR_READY && !I_FLUSH;
   end

   // Tag pipeline: stage 0 is loaded in the read cycle, the last stage lines up with the data.
   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         stage_valid_q <= '0;
         for (int i = 0; i < P_MEM_LATENCY; i++) begin
            stage_addr_q[i] <= '0;
         end
      end else begin
         stage_valid_q[0] <= accept;
         stage_addr_q[0]  <= I_ADDRESS;
         for (int i = 1; i < P_MEM_LATENCY; i++) begin
            stage_valid_q[i] <= stage_valid_q[i-1] && !I_FLUSH;
            stage_addr_q[i]  <= stage_addr_q[i-1];
         end
      end
   end

   always_comb begin
      if (I_FLUSH) begin
         inflight_count_d = '0;
      end else begin
         inflight_count_d = inflight_count_q + LP_CNT_W'(accept) - LP_CNT_W'(ret_valid);
      end
   end

   always_comb begin
      if (I_FLUSH) begin
         fifo_count_d = '0;
      end else begin
         fifo_count_d = fifo_count_q + LP_CNT_W'(push) - LP_CNT_W'(pop);
      end
   end

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         inflight_count_q <= '0;
         fifo_count_q     <= '0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
      end else begin
         inflight_count_q <= inflight_count_d;
         fifo_count_q     <= fifo_count_d;
         if (I_FLUSH) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) begin
               wr_ptr_q <= wr_ptr_q + LP_PTR_W'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + LP_PTR_W'(1);
            end
         end
      end
   end

   // Buffer storage needs no reset: the head is masked whenever the count is zero.
   always_ff @(posedge I_CLK) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= I_MEM_DATA;
         fifo_addr_q[wr_ptr_q] <= ret_addr;
      end
   end

   always_comb begin
      O_INSTR_VALID   = fifo_count_q != '0;
      O_INSTR         = O_INSTR_VALID ? fifo_data_q[rd_ptr_q] : '0;
      O_INSTR_ADDRESS = O_INSTR_VALID ? fifo_addr_q[rd_ptr_q] : '0;
   end

`ifdef INSTR_FETCH_STATS_EN
   logic [15:0] fetch_count_q;
   logic [15:0] discard_count_q;
   logic [16:0] discard_sum;

   always_comb begin
      discard_sum = {1'b0, discard_count_q} + 17'(pending_sum);
   end

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         fetch_count_q   <= '0;
         discard_count_q <= '0;
      end else begin
         if (pop && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_q <= fetch_count_q + 16'd1;
         end
         if (I_FLUSH) begin
            discard_count_q <= discard_sum[16] ? 16'hFFFF : discard_sum[15:0];
         end
      end
   end

   assign O_FETCH_COUNT   = fetch_count_q;
   assign O_DISCARD_COUNT = discard_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: two instances (memory latency 1 and 2) share stimulus; each is
// scored against its own queue model of buffered and outstanding fetches.
`timescale 1ns/1ps
module tb_instr_fetch;

   localparam int unsigned DEPTH = 4;

   typedef logic [31:0] ent_q_t [$];

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr;
   logic        addr_valid;
   logic        flush;
   logic        instr_ready;

   logic [1:0]  addr_ready;
   logic [1:0]  mem_read;
   logic [1:0]  instr_valid;
   logic [15:0] mem_addr   [2];
   logic [15:0] mem_data   [2];
   logic [15:0] instr      [2];
   logic [15:0] instr_addr [2];
`ifdef INSTR_FETCH_STATS_EN
   logic [15:0] fetch_cnt   [2];
   logic [15:0] discard_cnt [2];
`endif

   ent_q_t      sb [2];          // {addr, data} expected at the decoder, oldest first
   ent_q_t      fl [2];          // {age, addr} outstanding reads
   int unsigned exp_fetch   [2];
   int unsigned exp_discard [2];
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'h0010) return 16'hABCD;
      return {a[7:0], ~a[7:0]} ^ 16'h1234;
   endfunction

   function automatic int unsigned lat(input int k);
      return (k == 0) ? 1 : 2;
   endfunction

   // Instruction memory: word for the read address, exactly LAT cycles later.
   logic        m1_v = 1'b0;
   logic [15:0] m1_a = '0;
   logic [1:0]  m2_v = '0;
   logic [15:0] m2_a [2];

   always @(posedge clk) begin
      m1_v    <= mem_read[0];
      m1_a    <= mem_addr[0];
      m2_v    <= {m2_v[0], mem_read[1]};
      m2_a[0] <= mem_addr[1];
      m2_a[1] <= m2_a[0];
   end

   assign mem_data[0] = m1_v    ? mem_word(m1_a)    : 16'hDEAD;
   assign mem_data[1] = m2_v[1] ? mem_word(m2_a[1]) : 16'hDEAD;

   instr_fetch #(.P_MEM_LATENCY(1)) u_dut_l1 (
      .I_CLK           (clk),
      .I_RESET         (rst),
      .I_ADDRESS       (addr),
      .I_ADDRESS_VALID (addr_valid),
      .O_ADDRESS_READY (addr_ready[0]),
      .O_MEM_ADDRESS   (mem_addr[0]),
      .O_MEM_READ      (mem_read[0]),
      .I_MEM_DATA      (mem_data[0]),
      .I_FLUSH         (flush),
      .O_INSTR         (instr[0]),
      .O_INSTR_ADDRESS (instr_addr[0]),
      .O_INSTR_VALID   (instr_valid[0]),
`ifdef INSTR_FETCH_STATS_EN
      .O_FETCH_COUNT   (fetch_cnt[0]),
      .O_DISCARD_COUNT (discard_cnt[0]),
`endif
      .I_INSTR_READY   (instr_ready)
   );

   instr_fetch #(.P_MEM_LATENCY(2)) u_dut_l2 (
      .I_CLK           (clk),
      .I_RESET         (rst),
      .I_ADDRESS       (addr),
      .I_ADDRESS_VALID (addr_valid),
      .O_ADDRESS_READY (addr_ready[1]),
      .O_MEM_ADDRESS   (mem_addr[1]),
      .O_MEM_READ      (mem_read[1]),
      .I_MEM_DATA      (mem_data[1]),
      .I_FLUSH         (flush),
      .O_INSTR         (instr[1]),
      .O_INSTR_ADDRESS (instr_addr[1]),
      .O_INSTR_VALID   (instr_valid[1]),
`ifdef INSTR_FETCH_STATS_EN
      .O_FETCH_COUNT   (fetch_cnt[1]),
      .O_DISCARD_COUNT (discard_cnt[1]),
`endif
      .I_INSTR_READY   (instr_ready)
   );

   task automatic check(input string tag, input int k, input logic [31:0] obs,
                        input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         failures++;
         $error("FAIL %s dut_l%0d observed=%h expected=%h", tag, lat(k), obs, req);
      end
   endtask

   function automatic logic exp_ready(input int k);
      return !rst && !flush && ((sb[k].size() + fl[k].size()) < DEPTH);
   endfunction

   function automatic int unsigned sat16(input int unsigned v);
      return (v > 32'hFFFF) ? 32'hFFFF : v;
   endfunction

   task automatic check_outputs();
      logic [31:0] head;
      for (int k = 0; k < 2; k++) begin
         check("addr_ready", k, 32'(addr_ready[k]), 32'(exp_ready(k)));
         check("mem_read", k, 32'(mem_read[k]), 32'(addr_valid && exp_ready(k)));
         if (addr_valid && exp_ready(k)) check("mem_addr", k, 32'(mem_addr[k]), 32'(addr));
         check("instr_valid", k, 32'(instr_valid[k]), 32'(sb[k].size() != 0));
         if (sb[k].size() != 0) begin
            head = sb[k][0];
            check("instr", k, 32'(instr[k]), 32'(head[15:0]));
            check("instr_addr", k, 32'(instr_addr[k]), 32'(head[31:16]));
         end else if (rst) begin
            check("instr_rst", k, 32'(instr[k]), 32'h0);
            check("instr_addr_rst", k, 32'(instr_addr[k]), 32'h0);
         end
`ifdef INSTR_FETCH_STATS_EN
         check("fetch_count", k, 32'(fetch_cnt[k]), exp_fetch[k]);
         check("discard_count", k, 32'(discard_cnt[k]), exp_discard[k]);
`endif
      end
   endtask

   // Advance the model across one posedge using the inputs held during the cycle.
   task automatic update_model();
      for (int k = 0; k < 2; k++) begin
         logic        acc;
         logic [31:0] e;
         logic [7:0]  age;
         ent_q_t      nf;
         acc = addr_valid && exp_ready(k);
         if (rst) begin
            sb[k].delete();
            fl[k].delete();
            exp_fetch[k]   = 0;
            exp_discard[k] = 0;
         end else if (flush) begin
            exp_discard[k] = sat16(exp_discard[k] + sb[k].size() + fl[k].size());
            sb[k].delete();
            fl[k].delete();
         end else begin
            if (instr_ready && (sb[k].size() != 0)) begin
               void'(sb[k].pop_front());
               exp_fetch[k] = sat16(exp_fetch[k] + 1);
            end
            nf = {};
            for (int i = 0; i < fl[k].size(); i++) begin
               e   = fl[k][i];
               age = e[23:16] + 8'd1;
               if (32'(age) == lat(k)) sb[k].push_back({e[15:0], mem_word(e[15:0])});
               else nf.push_back({8'h0, age, e[15:0]});
            end
            fl[k] = nf;
            if (acc) fl[k].push_back({16'h0, addr});
         end
      end
   endtask

   task automatic step();
      #1;
      check_outputs();
      @(posedge clk);
      update_model();
      @(negedge clk);
   endtask

   // Present addresses from base while the latency-1 instance accepts, n cycles total.
   task automatic stream(input logic [15:0] base, input int n);
      addr = base;
      addr_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (exp_ready(0)) begin
            step();
            addr = addr + 16'd1;
         end else begin
            step();
         end
      end
      addr_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst = 1'b1; addr = '0; addr_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         sb[k].delete(); fl[k].delete();
         exp_fetch[k] = 0; exp_discard[k] = 0;
      end
      @(negedge clk);
      idle(2);
      rst = 1'b0;
      idle(1);

      // Single fetch of 0x0010 returning 0xABCD.
      instr_ready = 1'b1;
      stream(16'h0010, 1);
      idle(4);

      // Back-to-back stream with the decoder always ready.
      stream(16'h0000, 8);
      idle(5);

      // Decoder stalled: credit runs out at four, head holds, then drain.
      instr_ready = 1'b0;
      stream(16'h0030, 8);
      idle(2);
      instr_ready = 1'b1;
      idle(6);

      // Flush with one buffered and two outstanding (latency 2), two flush cycles.
      instr_ready = 1'b0;
      stream(16'h0020, 3);
      flush = 1'b1;
      idle(2);
      flush = 1'b0;
      instr_ready = 1'b1;
      stream(16'h0040, 1);
      idle(5);

      // Asynchronous reset mid-stream.
      stream(16'h0080, 4);
      addr_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_addr_ready", k, 32'(addr_ready[k]), 32'h0);
         check("rst_mem_read", k, 32'(mem_read[k]), 32'h0);
         check("rst_instr_valid", k, 32'(instr_valid[k]), 32'h0);
         check("rst_instr", k, 32'(instr[k]), 32'h0);
         check("rst_instr_addr", k, 32'(instr_addr[k]), 32'h0);
      end
      @(posedge clk);
      update_model();
      @(negedge clk);
      addr_valid = 1'b0;
      idle(2);
      rst = 1'b0;
      stream(16'h0100, 1);
      idle(5);

      // Statistics: five pops, then a flush with three pending.
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      instr_ready = 1'b1;
      stream(16'h0200, 5);
      idle(5);
      instr_ready = 1'b0;
      stream(16'h0300, 3);
      flush = 1'b1;
      idle(1);
      flush = 1'b0;
      idle(1);
`ifdef INSTR_FETCH_STATS_EN
      for (int k = 0; k < 2; k++) begin
         check("stats_fetch", k, 32'(fetch_cnt[k]), 32'd5);
         check("stats_discard", k, 32'(discard_cnt[k]), 32'd3);
      end
`endif
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
